// File: rtl/spi_bridge_seq_pkg.sv
// Shared definitions for the SPI bridge sequencer: register map, STATUS/CONTROL
// bit positions, sequencer and Avalon-transfer state encodings, completion codes.
package spi_bridge_seq_pkg;

  localparam logic [2:0] REG_RXDATA      = 3'd0;
  localparam logic [2:0] REG_TXDATA      = 3'd1;
  localparam logic [2:0] REG_STATUS      = 3'd2;
  localparam logic [2:0] REG_CONTROL     = 3'd3;
  localparam logic [2:0] REG_SLAVESELECT = 3'd5;

  localparam int STATUS_ROE  = 3;
  localparam int STATUS_TOE  = 4;
  localparam int STATUS_TMT  = 5;
  localparam int STATUS_TRDY = 6;
  localparam int STATUS_RRDY = 7;
  localparam int CONTROL_SSO = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SS,
    ST_WR_SSO,
    ST_POLL_TRDY,
    ST_WAIT_TX,
    ST_WR_TX,
    ST_POLL_RRDY,
    ST_RD_RX,
    ST_PUSH_RX,
    ST_POLL_TMT,
    ST_WR_REL,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    DONE_OK       = 2'd0,
    DONE_TIMEOUT  = 2'd1,
    DONE_OVERRUN  = 2'd2
  } done_status_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_CMD,
    XF_RESP
  } xfer_state_t;

  // Which STATUS bit a given poll state is waiting for.
  function automatic logic poll_hit(input state_t s, input logic [31:0] status);
    case (s)
      ST_POLL_TRDY: return status[STATUS_TRDY];
      ST_POLL_RRDY: return status[STATUS_RRDY];
      default:      return status[STATUS_TMT];
    endcase
  endfunction

endpackage

// File: rtl/spi_bridge_seq_xfer.sv
// Single Avalon-MM access engine: takes one request, holds it through waitrequest,
// waits for readdatavalid on reads, then pulses done with the read data.
module spi_avmm_xfer
  import spi_bridge_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_write,
  input  logic [2:0]  req_address,
  input  logic [31:0] req_writedata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [2:0]  avmm_address,
  output logic        avmm_read,
  output logic        avmm_write,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid,
  input  logic        avmm_waitrequest
);

  xfer_state_t xstate_reg, xstate_next;
  logic        read_reg, read_next;
  logic        write_reg, write_next;
  logic [2:0]  address_reg, address_next;
  logic [31:0] writedata_reg, writedata_next;
  logic        done_reg, done_next;
  logic [31:0] rdata_reg, rdata_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xstate_reg    <= XF_IDLE;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      address_reg   <= '0;
      writedata_reg <= '0;
      done_reg      <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      xstate_reg    <= xstate_next;
      read_reg      <= read_next;
      write_reg     <= write_next;
      address_reg   <= address_next;
      writedata_reg <= writedata_next;
      done_reg      <= done_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    xstate_next    = xstate_reg;
    read_next      = read_reg;
    write_next     = write_reg;
    address_next   = address_reg;
    writedata_next = writedata_reg;
    done_next      = 1'b0;
    rdata_next     = rdata_reg;
    case (xstate_reg)
      XF_IDLE: begin
        if (req) begin
          read_next      = !req_write;
          write_next     = req_write;
          address_next   = req_address;
          writedata_next = req_writedata;
          xstate_next    = XF_CMD;
        end
      end
      XF_CMD: begin
        // Command stays frozen on the bus until the slave stops stalling.
        if (!avmm_waitrequest) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          if (write_reg) begin
            done_next   = 1'b1;
            xstate_next = XF_IDLE;
          end else begin
            xstate_next = XF_RESP;
          end
        end
      end
      XF_RESP: begin
        if (avmm_readdatavalid) begin
          rdata_next  = avmm_readdata;
          done_next   = 1'b1;
          xstate_next = XF_IDLE;
        end
      end
      default: xstate_next = XF_IDLE;
    endcase
  end

  assign done           = done_reg;
  assign rdata          = rdata_reg;
  assign avmm_address   = address_reg;
  assign avmm_read      = read_reg;
  assign avmm_write     = write_reg;
  assign avmm_writedata = writedata_reg;

endmodule

// File: rtl/spi_bridge_seq.sv
// Command sequencer driving an Avalon-MM SPI bridge: selects a slave, streams
// cmd_len+1 words out/in through TXDATA/RXDATA with STATUS polling, then releases SS.
module spi_bridge_seq
  import spi_bridge_seq_pkg::*;
#(
  parameter int MAX_LEN_W  = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4:0]           cmd_ss,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  input  logic [31:0]          tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [31:0]          rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 done_valid,
  output logic [1:0]           done_status,
  output logic [2:0]           avmm_address,
  output logic                 avmm_read,
  output logic                 avmm_write,
  output logic [31:0]          avmm_writedata,
  input  logic [31:0]          avmm_readdata,
  input  logic                 avmm_readdatavalid,
  input  logic                 avmm_waitrequest
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  state_t               state_reg, state_next;
  logic [4:0]           ss_reg, ss_next;
  logic [MAX_LEN_W-1:0] words_reg, words_next;
  logic [31:0]          tx_word_reg, tx_word_next;
  logic [31:0]          rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  done_status_t         status_reg, status_next;
  logic [PCW-1:0]       poll_cnt_reg, poll_cnt_next;
  logic                 issued_reg, issued_next;
  logic                 cmd_ready_reg, cmd_ready_next;

  logic        xfer_req, xfer_write, xfer_done, is_access, step;
  logic [2:0]  xfer_address;
  logic [31:0] xfer_writedata, xfer_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ss_reg        <= '0;
      words_reg     <= '0;
      tx_word_reg   <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      status_reg    <= DONE_OK;
      poll_cnt_reg  <= '0;
      issued_reg    <= 1'b0;
      cmd_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ss_reg        <= ss_next;
      words_reg     <= words_next;
      tx_word_reg   <= tx_word_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      status_reg    <= status_next;
      poll_cnt_reg  <= poll_cnt_next;
      issued_reg    <= issued_next;
      cmd_ready_reg <= cmd_ready_next;
    end
  end

  assign is_access = (state_reg == ST_WR_SS)     || (state_reg == ST_WR_SSO)    ||
                     (state_reg == ST_POLL_TRDY) || (state_reg == ST_WR_TX)     ||
                     (state_reg == ST_POLL_RRDY) || (state_reg == ST_RD_RX)     ||
                     (state_reg == ST_POLL_TMT)  || (state_reg == ST_WR_REL);
  assign step = issued_reg && xfer_done;

  always_comb begin
    state_next     = state_reg;
    ss_next        = ss_reg;
    words_next     = words_reg;
    tx_word_next   = tx_word_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = rx_valid_reg;
    status_next    = status_reg;
    poll_cnt_next  = poll_cnt_reg;
    issued_next    = issued_reg;
    xfer_req       = 1'b0;
    xfer_write     = 1'b0;
    xfer_address   = REG_STATUS;
    xfer_writedata = '0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          ss_next     = cmd_ss;
          words_next  = cmd_len;
          status_next = DONE_OK;
          state_next  = ST_WR_SS;
        end
      end
      ST_WR_SS: begin
        xfer_write     = 1'b1;
        xfer_address   = REG_SLAVESELECT;
        xfer_writedata = 32'd1 << ss_reg;
        if (step) state_next = ST_WR_SSO;
      end
      ST_WR_SSO: begin
        xfer_write     = 1'b1;
        xfer_address   = REG_CONTROL;
        xfer_writedata = 32'd1 << CONTROL_SSO;
        if (step) state_next = ST_POLL_TRDY;
      end
      ST_POLL_TRDY, ST_POLL_RRDY, ST_POLL_TMT: begin
        if (step) begin
          poll_cnt_next = poll_cnt_reg + 1'b1;
          // Overrun is checked first so it wins over a simultaneous timeout.
          if (xfer_rdata[STATUS_ROE] || xfer_rdata[STATUS_TOE]) begin
            status_next = DONE_OVERRUN;
            state_next  = ST_WR_REL;
          end else if (poll_hit(state_reg, xfer_rdata)) begin
            case (state_reg)
              ST_POLL_TRDY: state_next = ST_WAIT_TX;
              ST_POLL_RRDY: state_next = ST_RD_RX;
              default:      state_next = ST_WR_REL;
            endcase
          end else if (poll_cnt_next == PCW'(POLL_LIMIT)) begin
            status_next = DONE_TIMEOUT;
            state_next  = ST_WR_REL;
          end
        end
      end
      ST_WAIT_TX: begin
        if (tx_valid) begin
          tx_word_next = tx_data;
          state_next   = ST_WR_TX;
        end
      end
      ST_WR_TX: begin
        xfer_write     = 1'b1;
        xfer_address   = REG_TXDATA;
        xfer_writedata = tx_word_reg;
        if (step) state_next = ST_POLL_RRDY;
      end
      ST_RD_RX: begin
        xfer_address = REG_RXDATA;
        if (step) begin
          rx_data_next  = xfer_rdata;
          rx_valid_next = 1'b1;
          state_next    = ST_PUSH_RX;
        end
      end
      ST_PUSH_RX: begin
        if (rx_ready) begin
          rx_valid_next = 1'b0;
          if (words_reg == '0) begin
            state_next = ST_POLL_TMT;
          end else begin
            words_next = words_reg - 1'b1;
            state_next = ST_POLL_TRDY;
          end
        end
      end
      ST_WR_REL: begin
        xfer_write     = 1'b1;
        xfer_address   = REG_CONTROL;
        xfer_writedata = '0;
        if (step) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // One request per visit; a poll state that stays put re-issues its read.
    if (is_access) begin
      if (!issued_reg) begin
        xfer_req    = 1'b1;
        issued_next = 1'b1;
      end else if (xfer_done) begin
        issued_next = 1'b0;
      end
    end
    if (state_next != state_reg) poll_cnt_next = '0;
  end

  assign cmd_ready_next = (state_next == ST_IDLE);

  spi_avmm_xfer u_xfer (
    .clk                (clk),
    .rst                (rst),
    .req                (xfer_req),
    .req_write          (xfer_write),
    .req_address        (xfer_address),
    .req_writedata      (xfer_writedata),
    .done               (xfer_done),
    .rdata              (xfer_rdata),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest)
  );

  assign cmd_ready   = cmd_ready_reg;
  assign tx_ready    = (state_reg == ST_WAIT_TX);
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign done_valid  = (state_reg == ST_DONE);
  assign done_status = (state_reg == ST_DONE) ? status_reg : DONE_OK;

endmodule

// File: tb/tb_spi_bridge_seq.sv
// Randomized bench for spi_bridge_seq with a behavioural SPI-bridge slave model
// and a transaction-level expectation of the register access sequence.
module tb_spi_bridge_seq;

  localparam int LW = 4;
  localparam int PL = 8;
  localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CTRL = 3'd3, A_SS = 3'd5;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [4:0] cmd_ss;
  logic [LW-1:0] cmd_len;
  logic [31:0] tx_data;
  logic tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic rx_valid, rx_ready;
  logic done_valid;
  logic [1:0] done_status;
  logic [2:0] avmm_address;
  logic avmm_read, avmm_write;
  logic [31:0] avmm_writedata, avmm_readdata;
  logic avmm_readdatavalid, avmm_waitrequest;

  spi_bridge_seq #(.MAX_LEN_W(LW), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ss(cmd_ss), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done_valid(done_valid), .done_status(done_status),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .avmm_waitrequest(avmm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- bridge slave model ----------------
  bit wait_rand = 0, trdy_never = 0, roe_mode = 0;
  int trdy_delay = 0;
  bit resp_pend, read_out, rx_pend, prev_wait;
  logic [31:0] resp_data, last_tx;
  logic [36:0] prev_req;
  int trdy_wait;
  logic [2:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int n_status_rd, n_rx_rd, n_acc, hold_errs, proto_errs;

  always @(negedge clk) begin
    logic [31:0] st;
    if (rst) begin
      resp_pend = 0; read_out = 0; rx_pend = 0; prev_wait = 0;
      avmm_readdatavalid = 1'b0; avmm_readdata = '0; avmm_waitrequest = 1'b0;
    end else begin
      if (prev_wait && ({avmm_read, avmm_write, avmm_address, avmm_writedata} !== prev_req)) hold_errs++;
      if (read_out && (avmm_read || avmm_write)) proto_errs++;
      if (avmm_read && avmm_write) proto_errs++;
      avmm_readdatavalid = resp_pend;
      avmm_readdata = resp_pend ? resp_data : $urandom;
      if (resp_pend) read_out = 0;
      resp_pend = 0;
      avmm_waitrequest = wait_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
      if ((avmm_read || avmm_write) && !avmm_waitrequest) begin
        n_acc++;
        if (avmm_write) begin
          wr_addr_q.push_back(avmm_address);
          wr_data_q.push_back(avmm_writedata);
          if (avmm_address == A_SS) begin rx_pend = 0; trdy_wait = trdy_delay; end
          if (avmm_address == A_TX) begin rx_pend = 1; last_tx = avmm_writedata; end
        end else begin
          read_out = 1; resp_pend = 1;
          if (avmm_address == A_ST) begin
            n_status_rd++;
            st = '0;
            st[5] = !rx_pend;
            st[6] = !trdy_never && !rx_pend && (trdy_wait == 0);
            st[7] = rx_pend;
            st[3] = roe_mode && rx_pend;
            if (!rx_pend && trdy_wait > 0) trdy_wait--;
            resp_data = st;
          end else if (avmm_address == A_RX) begin
            n_rx_rd++;
            resp_data = last_tx;
            rx_pend = 0;
            trdy_wait = trdy_delay;
          end else begin
            resp_data = '0;
          end
        end
      end
      prev_wait = (avmm_read || avmm_write) && avmm_waitrequest;
      prev_req = {avmm_read, avmm_write, avmm_address, avmm_writedata};
    end
  end

  // ---------------- command driver ----------------
  logic [31:0] txq[$], rxq[$];
  logic [2:0]  exp_a[$];
  logic [31:0] exp_d[$];
  int done_cnt, hold_viol;
  logic [1:0] last_status;
  bit rst_hit;

  task automatic run_cmd(input logic [4:0] ss, input logic [LW-1:0] len, input int hold_cycles,
                         input bit rst_on_tx, input string tag);
    int tx_idx = 0, cyc = 0, post = 0, hold_left = hold_cycles, acc0 = 0;
    bit taken = 0, hold_started = 0;
    logic [31:0] held = '0;
    rxq.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0; hold_viol = 0; n_status_rd = 0; n_rx_rd = 0; hold_errs = 0; proto_errs = 0;
    last_status = 2'd3; rst_hit = 0;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_ss = ss; cmd_len = len;
    while (1) begin
      if (rst_on_tx && avmm_write && avmm_address == A_TX) begin
        rst = 1'b1; #1;
        rst_hit = 1;
        check_val({tag, " rst outputs"}, {21'b0, cmd_ready, tx_ready, rx_valid, done_valid, done_status,
                  avmm_read, avmm_write, avmm_address}, 32'h0);
        check_val({tag, " rst writedata"}, avmm_writedata, 32'h0);
        break;
      end
      tx_valid = (tx_idx < txq.size()) && ($urandom_range(0, 2) != 0);
      tx_data  = tx_valid ? txq[tx_idx] : 32'h0;
      if (hold_started && hold_left > 0) begin
        if (!rx_valid || rx_data !== held || n_acc != acc0) hold_viol++;
        rx_ready = 1'b0; hold_left--;
      end else if (!hold_started && hold_left > 0 && rx_valid) begin
        hold_started = 1; held = rx_data; acc0 = n_acc; rx_ready = 1'b0; hold_left--;
      end else begin
        rx_ready = ($urandom_range(0, 1) == 1);
      end
      if (cmd_valid && cmd_ready) taken = 1;
      if (tx_valid && tx_ready) tx_idx++;
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (done_valid) begin done_cnt++; last_status = done_status; end
      @(negedge clk); #1;
      if (taken) cmd_valid = 1'b0;
      cyc++;
      if (done_cnt > 0) post++;
      if (post >= 3) break;
      if (cyc > 5000) begin
        check_val({tag, " completion within bound"}, 32'd0, 32'd1);
        break;
      end
    end
    cmd_valid = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    $display("cmd %s ss=%0d len=%0d status=%0d rx_words=%0d writes=%0d status_reads=%0d",
             tag, ss, len, last_status, rxq.size(), wr_addr_q.size(), n_status_rd);
  endtask

  task automatic check_cmd(input string tag, input logic [4:0] ss, input int n_tx, input int n_rx,
                           input logic [1:0] st, input int n_st);
    exp_a.delete(); exp_d.delete();
    exp_a.push_back(A_SS);   exp_d.push_back(32'd1 << ss);
    exp_a.push_back(A_CTRL); exp_d.push_back(32'h400);
    for (int i = 0; i < n_tx; i++) begin exp_a.push_back(A_TX); exp_d.push_back(txq[i]); end
    exp_a.push_back(A_CTRL); exp_d.push_back(32'h0);
    check_val({tag, " write count"}, wr_addr_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wr_addr_q.size(); i++) begin
      check_val($sformatf("%s write%0d addr", tag, i), {29'b0, wr_addr_q[i]}, {29'b0, exp_a[i]});
      check_val($sformatf("%s write%0d data", tag, i), wr_data_q[i], exp_d[i]);
    end
    check_val({tag, " rx count"}, rxq.size(), n_rx);
    for (int i = 0; i < n_rx && i < rxq.size(); i++)
      check_val($sformatf("%s rx%0d", tag, i), rxq[i], txq[i]);
    check_val({tag, " done_status"}, {30'b0, last_status}, {30'b0, st});
    check_val({tag, " done pulses"}, done_cnt, 1);
    check_val({tag, " status reads"}, n_status_rd, n_st);
    check_val({tag, " rxdata reads"}, n_rx_rd, n_rx);
    check_val({tag, " held during waitrequest"}, hold_errs, 0);
    check_val({tag, " single outstanding"}, proto_errs, 0);
  endtask

  initial begin
    int len, dly, n_rel;
    logic [4:0] ss;
    rst = 1'b1; cmd_valid = 0; cmd_ss = '0; cmd_len = '0; tx_valid = 0; tx_data = '0; rx_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset outputs", {21'b0, cmd_ready, tx_ready, rx_valid, done_valid, done_status,
              avmm_read, avmm_write, avmm_address}, 32'h0);
    check_val("reset writedata", avmm_writedata, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check_val("cmd_ready right after release", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk); #1;
    check_val("cmd_ready one cycle after release", {31'b0, cmd_ready}, 32'd1);

    // Basic echo, one word.
    wait_rand = 0; trdy_delay = 0;
    txq = '{32'h0000_00A5};
    run_cmd(5'd2, 4'd0, 0, 0, "basic");
    check_cmd("basic", 5'd2, 1, 1, 2'd0, 3);

    // Four words, slow TRDY, random waitrequest.
    wait_rand = 1; trdy_delay = 5;
    txq.delete(); for (int i = 0; i < 4; i++) txq.push_back($urandom);
    run_cmd(5'd7, 4'd3, 0, 0, "multi");
    check_cmd("multi", 5'd7, 4, 4, 2'd0, 4 * 7 + 1);

    // TRDY never asserted -> timeout after PL polls.
    wait_rand = 0; trdy_never = 1; trdy_delay = 0;
    txq = '{32'h1234_5678};
    run_cmd(5'd0, 4'd0, 0, 0, "timeout");
    check_cmd("timeout", 5'd0, 0, 0, 2'd1, PL);
    trdy_never = 0;

    // ROE while polling RRDY -> overrun, no RXDATA read.
    roe_mode = 1;
    txq.delete(); for (int i = 0; i < 3; i++) txq.push_back($urandom);
    run_cmd(5'd31, 4'd2, 0, 0, "overrun");
    check_cmd("overrun", 5'd31, 1, 0, 2'd2, 2);
    roe_mode = 0;

    // Receiver stalls 20 cycles on the first word.
    wait_rand = 1; trdy_delay = 1;
    txq.delete(); for (int i = 0; i < 2; i++) txq.push_back($urandom);
    run_cmd(5'd4, 4'd1, 20, 0, "rxhold");
    check_cmd("rxhold", 5'd4, 2, 2, 2'd0, 2 * 3 + 1);
    check_val("rxhold stable", hold_viol, 0);

    // Reset in the middle of a TXDATA write.
    wait_rand = 1; trdy_delay = 0;
    txq.delete(); for (int i = 0; i < 4; i++) txq.push_back($urandom);
    run_cmd(5'd9, 4'd3, 0, 1, "midrst");
    check_val("midrst reached WR_TX", {31'b0, rst_hit}, 32'd1);
    n_rel = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] == A_CTRL && wr_data_q[i] == 32'h0) n_rel++;
    check_val("midrst no release", n_rel, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    check_val("midrst cmd_ready at release", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk); #1;
    check_val("midrst cmd_ready after release", {31'b0, cmd_ready}, 32'd1);
    txq.delete(); for (int i = 0; i < 2; i++) txq.push_back($urandom);
    run_cmd(5'd9, 4'd1, 0, 0, "postrst");
    check_cmd("postrst", 5'd9, 2, 2, 2'd0, 2 * 2 + 1);

    // Randomized commands.
    for (int r = 0; r < 4; r++) begin
      ss = 5'($urandom_range(0, 31));
      len = $urandom_range(0, 15);
      dly = $urandom_range(0, 6);
      wait_rand = ($urandom_range(0, 1) == 1);
      trdy_delay = dly;
      txq.delete(); for (int i = 0; i <= len; i++) txq.push_back($urandom);
      run_cmd(ss, LW'(len), 0, 0, $sformatf("rand%0d", r));
      check_cmd($sformatf("rand%0d", r), ss, len + 1, len + 1, 2'd0, (len + 1) * (dly + 2) + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
